// File: rtl/periph_axil_responder.sv
// periph_axil_responder: AXI-Lite slave exposing NumRegs 64-bit registers
// starting at BaseAddr. Independent write (AW+W -> B) and read (AR -> R)
// engines; out-of-range accesses answer SLVERR and touch nothing.
//
// Handshake rule used on every channel: a beat transfers on the rising edge
// where valid and ready are both high; a source holds valid and payload
// stable until that edge, and every ready here depends only on registered
// state, never on an incoming valid.
module periph_axil_responder #(
    parameter int          AddrWidth = 64,
    parameter int          DataWidth = 64,
    parameter int          NumRegs   = 8,
    parameter logic [63:0] BaseAddr  = 64'h4000_0000
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    // write address
    input  logic                           awvalid_i,
    output logic                           awready_o,
    input  logic [AddrWidth-1:0]           awaddr_i,
    // write data
    input  logic                           wvalid_i,
    output logic                           wready_o,
    input  logic [DataWidth-1:0]           wdata_i,
    input  logic [DataWidth/8-1:0]         wstrb_i,
    // write response
    output logic                           bvalid_o,
    input  logic                           bready_i,
    output logic [1:0]                     bresp_o,
    // read address
    input  logic                           arvalid_i,
    output logic                           arready_o,
    input  logic [AddrWidth-1:0]           araddr_i,
    // read data
    output logic                           rvalid_o,
    input  logic                           rready_i,
    output logic [DataWidth-1:0]           rdata_o,
    output logic [1:0]                     rresp_o,
    // register view and commit strobes
    output logic [NumRegs*DataWidth-1:0]   regs_o,
    output logic [NumRegs-1:0]             wr_pulse_o,
    // FSM state visibility
    output logic                           dbg_w_state_o,
    output logic                           dbg_r_state_o
);

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int IdxW = (NumRegs > 1) ? $clog2(NumRegs) : 1;
    localparam int NumBytes = DataWidth / 8;
    localparam logic [AddrWidth-1:0] BASE = BaseAddr[AddrWidth-1:0];
    localparam logic [AddrWidth-1:0] SPAN = AddrWidth'(NumRegs * 8);

    // state
    logic [0:0]            r_wstate;
    logic [0:0]            r_rstate;
    logic                  r_aw_latched;
    logic [AddrWidth-1:0]  r_awaddr;
    logic                  r_w_latched;
    logic [DataWidth-1:0]  r_wdata;
    logic [NumBytes-1:0]   r_wstrb;
    logic [1:0]            r_bresp;
    logic [DataWidth-1:0]  r_rdata;
    logic [1:0]            r_rresp;
    logic [NumRegs-1:0]    r_wr_pulse;
    logic [DataWidth-1:0]  r_regs [NumRegs];

    // write-side combinational
    logic                  w_aw_fire;
    logic                  w_w_fire;
    logic                  w_commit;
    logic [AddrWidth-1:0]  w_waddr;
    logic [DataWidth-1:0]  w_wdata;
    logic [NumBytes-1:0]   w_wstrb;
    logic [AddrWidth-1:0]  w_woff;
    logic                  w_w_inrange;
    logic [IdxW-1:0]       w_widx;

    // read-side combinational
    logic                  w_ar_fire;
    logic [AddrWidth-1:0]  w_roff;
    logic                  w_r_inrange;
    logic [IdxW-1:0]       w_ridx;

    // Readies come purely from state and latch flags (no valid->ready path).
    assign awready_o = (r_wstate == W_IDLE) && !r_aw_latched;
    assign wready_o  = (r_wstate == W_IDLE) && !r_w_latched;
    assign arready_o = (r_rstate == R_IDLE);

    assign bvalid_o  = (r_wstate == W_RESP);
    assign bresp_o   = r_bresp;
    assign rvalid_o  = (r_rstate == R_DATA);
    assign rdata_o   = r_rdata;
    assign rresp_o   = r_rresp;
    assign wr_pulse_o = r_wr_pulse;

    assign dbg_w_state_o = r_wstate;
    assign dbg_r_state_o = r_rstate;

    assign w_aw_fire = awvalid_i && awready_o;
    assign w_w_fire  = wvalid_i && wready_o;

    // A write commits as soon as both halves are held, either from an earlier
    // latch or from a beat arriving on this very edge.
    assign w_commit = (r_wstate == W_IDLE)
                    && (r_aw_latched || w_aw_fire)
                    && (r_w_latched  || w_w_fire);

    assign w_waddr = r_aw_latched ? r_awaddr : awaddr_i;
    assign w_wdata = r_w_latched  ? r_wdata  : wdata_i;
    assign w_wstrb = r_w_latched  ? r_wstrb  : wstrb_i;

    // Address decode: the subtraction wraps in AddrWidth bits, so the explicit
    // lower-bound test rejects addresses below the base that wrap into range.
    assign w_woff      = w_waddr - BASE;
    assign w_w_inrange = (w_waddr >= BASE) && (w_woff < SPAN);
    assign w_widx      = w_woff[IdxW+2:3];

    assign w_ar_fire   = arvalid_i && arready_o;
    assign w_roff      = araddr_i - BASE;
    assign w_r_inrange = (araddr_i >= BASE) && (w_roff < SPAN);
    assign w_ridx      = w_roff[IdxW+2:3];

    // Flatten the register file onto regs_o.
    for (genvar k = 0; k < NumRegs; k++) begin : g_regs_out
        assign regs_o[k*DataWidth +: DataWidth] = r_regs[k];
    end

    // Write channel: latch AW/W independently, commit when both present,
    // then hold the response until the master takes it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wstate     <= W_IDLE;
            r_aw_latched <= 1'b0;
            r_awaddr     <= '0;
            r_w_latched  <= 1'b0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_bresp      <= RESP_OKAY;
            r_wr_pulse   <= '0;
            for (int k = 0; k < NumRegs; k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            r_wr_pulse <= '0;
            case (r_wstate)
                W_IDLE: begin
                    if (w_commit) begin
                        // Latches are dropped here; readies stay low through
                        // W_RESP, so no new beat is taken before the B handshake.
                        r_aw_latched <= 1'b0;
                        r_w_latched  <= 1'b0;
                        r_wstate     <= W_RESP;
                        if (w_w_inrange) begin
                            r_bresp <= RESP_OKAY;
                            r_wr_pulse[w_widx] <= 1'b1;
                            for (int b = 0; b < NumBytes; b++) begin
                                if (w_wstrb[b]) begin
                                    r_regs[w_widx][8*b +: 8] <= w_wdata[8*b +: 8];
                                end
                            end
                        end else begin
                            r_bresp <= RESP_SLVERR;
                        end
                    end else begin
                        if (w_aw_fire) begin
                            r_aw_latched <= 1'b1;
                            r_awaddr     <= awaddr_i;
                        end
                        if (w_w_fire) begin
                            r_w_latched <= 1'b1;
                            r_wdata     <= wdata_i;
                            r_wstrb     <= wstrb_i;
                        end
                    end
                end
                W_RESP: begin
                    if (bready_i) begin
                        r_wstate <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Read channel: sample the register on AR acceptance (pre-write value if
    // a write commits on the same edge) and hold it until R is taken.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rstate <= R_IDLE;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_fire) begin
                        r_rstate <= R_DATA;
                        if (w_r_inrange) begin
                            r_rdata <= r_regs[w_ridx];
                            r_rresp <= RESP_OKAY;
                        end else begin
                            r_rdata <= '0;
                            r_rresp <= RESP_SLVERR;
                        end
                    end
                end
                R_DATA: begin
                    if (rready_i) begin
                        r_rstate <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_periph_axil_responder.sv
// Directed bench for periph_axil_responder (default parameters: 8 regs at
// 0x4000_0000). Inputs change 1 ns after a rising edge; outputs are checked
// at that same point, well away from the next edge.
module tb_periph_axil_responder;

    logic          clk;
    logic          rst;
    logic          awvalid, awready;
    logic [63:0]   awaddr;
    logic          wvalid, wready;
    logic [63:0]   wdata;
    logic [7:0]    wstrb;
    logic          bvalid, bready;
    logic [1:0]    bresp;
    logic          arvalid, arready;
    logic [63:0]   araddr;
    logic          rvalid, rready;
    logic [63:0]   rdata;
    logic [1:0]    rresp;
    logic [511:0]  regs;
    logic [7:0]    wr_pulse;
    logic          dbg_w_state, dbg_r_state;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_regs [8];

    periph_axil_responder dut (
        .clk_i(clk), .rst_i(rst),
        .awvalid_i(awvalid), .awready_o(awready), .awaddr_i(awaddr),
        .wvalid_i(wvalid), .wready_o(wready), .wdata_i(wdata), .wstrb_i(wstrb),
        .bvalid_o(bvalid), .bready_i(bready), .bresp_o(bresp),
        .arvalid_i(arvalid), .arready_o(arready), .araddr_i(araddr),
        .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata), .rresp_o(rresp),
        .regs_o(regs), .wr_pulse_o(wr_pulse),
        .dbg_w_state_o(dbg_w_state), .dbg_r_state_o(dbg_r_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("%s_reg%0d", tag, k), regs[k*64 +: 64], exp_regs[k]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        awvalid = 1'b0; awaddr = '0;
        wvalid  = 1'b0; wdata  = '0; wstrb = '0;
        arvalid = 1'b0; araddr = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        bready = 1'b1;
        rready = 1'b1;
        for (int k = 0; k < 8; k++) exp_regs[k] = '0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_bvalid", 64'(bvalid), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_rdata", rdata, 64'd0);
        check("rst_wr_pulse", 64'(wr_pulse), 64'd0);
        check("rst_wstate", 64'(dbg_w_state), 64'd0);
        check_regs("rst");
        rst = 1'b0;
        tick();
        check("idle_awready", 64'(awready), 64'd1);
        check("idle_wready", 64'(wready), 64'd1);
        check("idle_arready", 64'(arready), 64'd1);

        // AW and W in the same cycle, full strobe
        awvalid = 1'b1; awaddr = 64'h4000_0008;
        wvalid = 1'b1; wdata = 64'h1122_3344_5566_7788; wstrb = 8'hFF;
        tick();
        idle_inputs();
        exp_regs[1] = 64'h1122_3344_5566_7788;
        check("same_bvalid", 64'(bvalid), 64'd1);
        check("same_bresp", 64'(bresp), 64'd0);
        check("same_pulse", 64'(wr_pulse), 64'h02);
        check("same_awready", 64'(awready), 64'd0);
        check_regs("same");
        tick();
        check("same_bdone", 64'(bvalid), 64'd0);
        check("same_pulse_clr", 64'(wr_pulse), 64'd0);
        check("same_awready_back", 64'(awready), 64'd1);

        // W first with low-half strobe, AW three cycles later
        wvalid = 1'b1; wdata = 64'hFFFF_FFFF_AAAA_BBBB; wstrb = 8'h0F;
        tick();
        idle_inputs();
        check("wfirst_wready", 64'(wready), 64'd0);
        check("wfirst_awready", 64'(awready), 64'd1);
        check("wfirst_nob0", 64'(bvalid), 64'd0);
        tick();
        check("wfirst_nob1", 64'(bvalid), 64'd0);
        tick();
        awvalid = 1'b1; awaddr = 64'h4000_0008;
        tick();
        idle_inputs();
        exp_regs[1] = 64'h1122_3344_AAAA_BBBB;
        check("wfirst_bvalid", 64'(bvalid), 64'd1);
        check("wfirst_pulse", 64'(wr_pulse), 64'h02);
        check_regs("wfirst");
        tick();
        check("wfirst_single_b", 64'(bvalid), 64'd0);

        // zero strobe: nothing written, still pulses and answers OKAY
        awvalid = 1'b1; awaddr = 64'h4000_000C;
        wvalid = 1'b1; wdata = 64'hDEAD_BEEF_DEAD_BEEF; wstrb = 8'h00;
        tick();
        idle_inputs();
        check("strb0_bresp", 64'(bresp), 64'd0);
        check("strb0_pulse", 64'(wr_pulse), 64'h02);
        check_regs("strb0");
        tick();

        // out-of-range read just past the last register
        rready = 1'b0;
        arvalid = 1'b1; araddr = 64'h4000_0040;
        tick();
        idle_inputs();
        check("oor_rvalid", 64'(rvalid), 64'd1);
        check("oor_rdata", rdata, 64'd0);
        check("oor_rresp", 64'(rresp), 64'd2);
        check("oor_arready", 64'(arready), 64'd0);
        rready = 1'b1;
        tick();
        check("oor_rdone", 64'(rvalid), 64'd0);

        // out-of-range write just below the base
        awvalid = 1'b1; awaddr = 64'h3FFF_FFF8;
        wvalid = 1'b1; wdata = 64'hFFFF_FFFF_FFFF_FFFF; wstrb = 8'hFF;
        tick();
        idle_inputs();
        check("oorw_bvalid", 64'(bvalid), 64'd1);
        check("oorw_bresp", 64'(bresp), 64'd2);
        check("oorw_pulse", 64'(wr_pulse), 64'd0);
        check_regs("oorw");
        tick();

        // B back-pressure: response and readies hold for 5 cycles
        bready = 1'b0;
        awvalid = 1'b1; awaddr = 64'h4000_0038;
        wvalid = 1'b1; wdata = 64'hCAFE_0000_0000_0007; wstrb = 8'hFF;
        tick();
        exp_regs[7] = 64'hCAFE_0000_0000_0007;
        awaddr = 64'h4000_0000;  // still offered, must not be taken
        wdata = 64'h1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bstall%0d_bvalid", i), 64'(bvalid), 64'd1);
            check($sformatf("bstall%0d_bresp", i), 64'(bresp), 64'd0);
            check($sformatf("bstall%0d_aw_w_ready", i), 64'({awready, wready}), 64'd0);
            tick();
        end
        idle_inputs();
        check_regs("bstall");
        bready = 1'b1;
        tick();
        check("bstall_done", 64'(bvalid), 64'd0);

        // R back-pressure: data holds for 5 cycles
        rready = 1'b0;
        arvalid = 1'b1; araddr = 64'h4000_0008;
        tick();
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rstall%0d_rvalid", i), 64'(rvalid), 64'd1);
            check($sformatf("rstall%0d_rdata", i), rdata, 64'h1122_3344_AAAA_BBBB);
            check($sformatf("rstall%0d_arready", i), 64'(arready), 64'd0);
            tick();
        end
        rready = 1'b1;
        tick();
        check("rstall_done", 64'(rvalid), 64'd0);

        // same-edge read and write of reg2: read sees the old value
        arvalid = 1'b1; araddr = 64'h4000_0010;
        awvalid = 1'b1; awaddr = 64'h4000_0010;
        wvalid = 1'b1; wdata = 64'h55; wstrb = 8'hFF;
        tick();
        idle_inputs();
        exp_regs[2] = 64'h55;
        check("rw_rvalid", 64'(rvalid), 64'd1);
        check("rw_rdata_old", rdata, 64'd0);
        check("rw_rresp", 64'(rresp), 64'd0);
        check("rw_bvalid", 64'(bvalid), 64'd1);
        check("rw_reg2_new", regs[2*64 +: 64], 64'h55);
        tick();
        arvalid = 1'b1; araddr = 64'h4000_0010;
        tick();
        idle_inputs();
        check("rw_reread", rdata, 64'h55);
        tick();

        // reset in the middle of W_RESP and R_DATA
        bready = 1'b0; rready = 1'b0;
        awvalid = 1'b1; awaddr = 64'h4000_0000;
        wvalid = 1'b1; wdata = 64'h77; wstrb = 8'hFF;
        arvalid = 1'b1; araddr = 64'h4000_0008;
        tick();
        idle_inputs();
        check("mid_bvalid", 64'(bvalid), 64'd1);
        check("mid_rvalid", 64'(rvalid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) exp_regs[k] = '0;
        check("arst_bvalid", 64'(bvalid), 64'd0);
        check("arst_rvalid", 64'(rvalid), 64'd0);
        check("arst_rdata", rdata, 64'd0);
        check("arst_bresp", 64'(bresp), 64'd0);
        check_regs("arst");
        bready = 1'b1; rready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("post_awready", 64'(awready), 64'd1);
        check("post_bvalid", 64'(bvalid), 64'd0);
        awvalid = 1'b1; awaddr = 64'h4000_0038;
        wvalid = 1'b1; wdata = 64'h99; wstrb = 8'hFF;
        tick();
        idle_inputs();
        exp_regs[7] = 64'h99;
        check("post_bvalid1", 64'(bvalid), 64'd1);
        check("post_bresp", 64'(bresp), 64'd0);
        check("post_pulse", 64'(wr_pulse), 64'h80);
        check_regs("post");
        tick();
        check("post_bdone", 64'(bvalid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
